// File: rtl/imem_loader_ctrl_if.sv
// rtl/imem_loader_ctrl_if.sv - byte stream input and imem write port bundle for the program loader
interface imem_loader_ctrl_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader_ctrl.sv
// rtl/imem_loader_ctrl.sv - framed byte-stream loader that writes RV32I imem and holds the core in reset
module imem_loader_ctrl #(
   parameter int DEPTH   = 64,
   parameter int TIMEOUT = 100000,
   parameter int CW      = 17
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   imem_loader_ctrl_if.slave  bus,
   output logic               cpu_hold,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code
);
   localparam int WI = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_WR, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t          state, state_nxt;
   logic [31:0]     cnt;
   logic [31:0]     word_sr;
   logic [7:0]      csum;
   logic [1:0]      byte_idx;
   logic [WI-1:0]   word_idx;
   logic [CW-1:0]   timer;
   logic [1:0]      err_pend;

   logic            ready_c, we_c, xfer;
   logic [1:0]      code_c;
   logic [31:0]     len_full;
   logic [CW-1:0]   timer_inc;
   logic            tmo, last_word;

   assign len_full  = {bus.in_data, cnt[31:8]};
   assign timer_inc = timer + 1'b1;
   assign tmo       = (timer_inc == CW'(TIMEOUT));
   assign last_word = ((32'(word_idx) + 32'd1) == cnt);
   assign xfer      = ready_c & bus.in_valid;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready_c   = 1'b0;
      we_c      = 1'b0;
      code_c    = 2'd0;
      case (state)
         S_IDLE: if (start) state_nxt = S_LEN;
         S_LEN: begin
            ready_c = 1'b1;
            if (bus.in_valid) begin
               if (byte_idx == 2'd3) begin
                  if (len_full > 32'(DEPTH)) begin
                     state_nxt = S_ERR;
                     code_c    = 2'd1;
                  end else if (len_full == 32'd0) begin
                     state_nxt = S_CSUM;
                  end else begin
                     state_nxt = S_DATA;
                  end
               end
            end else if (tmo) begin
               state_nxt = S_ERR;
               code_c    = 2'd3;
            end
         end
         S_DATA: begin
            ready_c = 1'b1;
            if (bus.in_valid) begin
               if (byte_idx == 2'd3) state_nxt = S_WR;
            end else if (tmo) begin
               state_nxt = S_ERR;
               code_c    = 2'd3;
            end
         end
         // Write cycle of DATA: input is stalled and the timer is frozen.
         S_WR: begin
            we_c      = 1'b1;
            state_nxt = last_word ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            ready_c = 1'b1;
            if (bus.in_valid) begin
               if (bus.in_data == csum) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_ERR;
                  code_c    = 2'd2;
               end
            end else if (tmo) begin
               state_nxt = S_ERR;
               code_c    = 2'd3;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.in_ready  = ready_c;
   assign bus.mem_we    = we_c;
   assign bus.mem_addr  = 32'(word_idx) << 2;
   assign bus.mem_wdata = word_sr;

   // Status flags change on leaving DONE/ERR, so they appear the cycle after entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         word_sr  <= '0;
         csum     <= '0;
         byte_idx <= '0;
         word_idx <= '0;
         timer    <= '0;
         err_pend <= '0;
         cpu_hold <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt      <= '0;
                  word_sr  <= '0;
                  csum     <= '0;
                  byte_idx <= '0;
                  word_idx <= '0;
                  timer    <= '0;
                  err_pend <= '0;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  err_code <= 2'd0;
                  busy     <= 1'b1;
                  cpu_hold <= 1'b1;
               end
            end
            S_LEN, S_DATA, S_CSUM: begin
               if (xfer) begin
                  timer    <= '0;
                  byte_idx <= byte_idx + 2'd1;
                  if (state == S_LEN) cnt <= len_full;
                  if (state == S_DATA) begin
                     word_sr <= {bus.in_data, word_sr[31:8]};
                     csum    <= csum ^ bus.in_data;
                  end
               end else begin
                  timer <= timer_inc;
               end
            end
            S_WR: word_idx <= word_idx + 1'b1;
            S_DONE: begin
               done     <= 1'b1;
               busy     <= 1'b0;
               cpu_hold <= 1'b0;
            end
            S_ERR: begin
               err      <= 1'b1;
               err_code <= err_pend;
               busy     <= 1'b0;
            end
            default: ;
         endcase
         if (code_c != 2'd0) err_pend <= code_c;
      end
   end
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb/tb_imem_loader_ctrl.sv - directed self-checking bench for imem_loader_ctrl
module tb_imem_loader_ctrl;
   localparam int TO = 40;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       cpu_hold, busy, done, err;
   logic [1:0] err_code;

   int checks = 0;
   int errors = 0;

   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          nw0;

   imem_loader_ctrl_if bus ();

   imem_loader_ctrl #(.DEPTH(64), .TIMEOUT(TO), .CW(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wa.push_back(bus.mem_addr);
         wd.push_back(bus.mem_wdata);
         chk("ready_on_we", {31'b0, bus.in_ready}, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) chk("tx_ready", {31'b0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
      chk({pfx, "_mem_we"},   {31'b0, bus.mem_we},   32'd0);
      chk({pfx, "_mem_addr"}, bus.mem_addr,          32'd0);
      chk({pfx, "_mem_wdata"}, bus.mem_wdata,        32'd0);
      chk({pfx, "_busy"},     {31'b0, busy},         32'd0);
      chk({pfx, "_done"},     {31'b0, done},         32'd0);
      chk({pfx, "_err"},      {31'b0, err},          32'd0);
      chk({pfx, "_err_code"}, {30'b0, err_code},     32'd0);
      chk({pfx, "_cpu_hold"}, {31'b0, cpu_hold},     32'd0);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      start        = 1'b0;
      reset        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      reset = 1'b0;
      tick();

      // Normal two-word load; checksum = 13^B3^10 = B0
      nw0 = wa.size();
      pulse_start();
      chk("norm_busy_start", {31'b0, busy}, 32'd1);
      chk("norm_hold_start", {31'b0, cpu_hold}, 32'd1);
      chk("norm_ready_len", {31'b0, bus.in_ready}, 32'd1);
      send_word(32'd2);
      send_word(32'h0000_0013);
      send_word(32'h0010_00B3);
      send_byte(8'hB0);
      chk("norm_done_entry", {31'b0, done}, 32'd0);
      chk("norm_hold_entry", {31'b0, cpu_hold}, 32'd1);
      tick();
      chk("norm_done", {31'b0, done}, 32'd1);
      chk("norm_err", {31'b0, err}, 32'd0);
      chk("norm_busy", {31'b0, busy}, 32'd0);
      chk("norm_hold", {31'b0, cpu_hold}, 32'd0);
      chk("norm_nwr", wa.size() - nw0, 32'd2);
      chk("norm_a0", wa[nw0], 32'd0);
      chk("norm_d0", wd[nw0], 32'h0000_0013);
      chk("norm_a1", wa[nw0+1], 32'd4);
      chk("norm_d1", wd[nw0+1], 32'h0010_00B3);

      // Bad checksum
      nw0 = wa.size();
      pulse_start();
      chk("badc_done_clr", {31'b0, done}, 32'd0);
      send_word(32'd2);
      send_word(32'h0000_0013);
      send_word(32'h0010_00B3);
      send_byte(8'h00);
      chk("badc_err_entry", {31'b0, err}, 32'd0);
      tick();
      chk("badc_err", {31'b0, err}, 32'd1);
      chk("badc_code", {30'b0, err_code}, 32'd2);
      chk("badc_busy", {31'b0, busy}, 32'd0);
      chk("badc_hold", {31'b0, cpu_hold}, 32'd1);
      chk("badc_nwr", wa.size() - nw0, 32'd2);
      chk("badc_d1", wd[nw0+1], 32'h0010_00B3);

      // Oversize length 0x41
      nw0 = wa.size();
      pulse_start();
      chk("over_err_clr", {31'b0, err}, 32'd0);
      send_word(32'h0000_0041);
      chk("over_ready_err", {31'b0, bus.in_ready}, 32'd0);
      tick();
      chk("over_err", {31'b0, err}, 32'd1);
      chk("over_code", {30'b0, err_code}, 32'd1);
      chk("over_hold", {31'b0, cpu_hold}, 32'd1);
      chk("over_nwr", wa.size() - nw0, 32'd0);

      // Zero length, good then bad checksum
      nw0 = wa.size();
      pulse_start();
      send_word(32'd0);
      send_byte(8'h00);
      tick();
      chk("zero_done", {31'b0, done}, 32'd1);
      chk("zero_err", {31'b0, err}, 32'd0);
      chk("zero_code", {30'b0, err_code}, 32'd0);
      chk("zero_hold", {31'b0, cpu_hold}, 32'd0);
      chk("zero_nwr", wa.size() - nw0, 32'd0);
      pulse_start();
      send_word(32'd0);
      send_byte(8'h01);
      tick();
      chk("zerob_err", {31'b0, err}, 32'd1);
      chk("zerob_code", {30'b0, err_code}, 32'd2);

      // Timeout after two bytes of the second word
      nw0 = wa.size();
      pulse_start();
      send_word(32'd2);
      send_word(32'h4433_2211);
      send_byte(8'h55);
      send_byte(8'h66);
      repeat (TO - 1) @(posedge clk);
      #1;
      chk("tmo_ready_wait", {31'b0, bus.in_ready}, 32'd1);
      chk("tmo_err_wait", {31'b0, err}, 32'd0);
      tick();
      chk("tmo_ready_err", {31'b0, bus.in_ready}, 32'd0);
      chk("tmo_busy_err", {31'b0, busy}, 32'd1);
      tick();
      chk("tmo_err", {31'b0, err}, 32'd1);
      chk("tmo_code", {30'b0, err_code}, 32'd3);
      chk("tmo_busy", {31'b0, busy}, 32'd0);
      chk("tmo_hold", {31'b0, cpu_hold}, 32'd1);
      chk("tmo_nwr", wa.size() - nw0, 32'd1);
      chk("tmo_d0", wd[nw0], 32'h4433_2211);

      // Reset mid-DATA after one word written
      pulse_start();
      send_word(32'd2);
      send_word(32'h0403_0201);
      send_byte(8'h05);
      chk("mid_addr", bus.mem_addr, 32'd4);
      chk("mid_busy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      chk_reset_vals("midrst");
      reset = 1'b0;
      tick();

      // One-word load with an ignored start pulse; checksum EF^BE^AD^DE = 22
      nw0 = wa.size();
      pulse_start();
      send_byte(8'h01);
      start = 1'b1;
      send_byte(8'h00);
      start = 1'b0;
      chk("ign_busy", {31'b0, busy}, 32'd1);
      chk("ign_ready", {31'b0, bus.in_ready}, 32'd1);
      send_byte(8'h00);
      send_byte(8'h00);
      send_word(32'hDEAD_BEEF);
      send_byte(8'h22);
      tick();
      chk("one_done", {31'b0, done}, 32'd1);
      chk("one_err", {31'b0, err}, 32'd0);
      chk("one_hold", {31'b0, cpu_hold}, 32'd0);
      chk("one_nwr", wa.size() - nw0, 32'd1);
      chk("one_a0", wa[nw0], 32'd0);
      chk("one_d0", wd[nw0], 32'hDEAD_BEEF);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
